// File: rtl/mips_control_fsm.sv
// Multicycle MIPS control unit: a 12-state controller for a lw/sw/R-type/beq/addi/j datapath.
// Moore controls are registered from the next state; pcEn, irWrite, illegalOp and the EXECUTE aluOp follow live inputs.
module mips_control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zeroFlag,
    input  logic       memReady,
    output logic [2:0] aluOp,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] pcSrc,
    output logic       iorD,
    output logic       irWrite,
    output logic       memWrite,
    output logic       regDst,
    output logic       memToReg,
    output logic       regWrite,
    output logic       pcEn,
    output logic       illegalOp,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       ior_d;
        logic       mem_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Unlisted states (including the unused codes) decode to all-zero controls.
    function automatic ctrl_t moore_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:    c.alu_src_b = 2'b01;
            DECODE:   c.alu_src_b = 2'b11;
            MEMADR:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            MEMRD:    c.ior_d = 1'b1;
            MEMWB:    begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            MEMWR:    begin c.ior_d = 1'b1; c.mem_write = 1'b1; end
            EXECUTE:  c.alu_src_a = 1'b1;
            ALUWB:    begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
            BRANCH:   begin c.alu_src_a = 1'b1; c.alu_op = 3'b001; c.pc_src = 2'b01; end
            ADDIEXEC: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            ADDIWB:   c.reg_write = 1'b1;
            JUMP:     c.pc_src = 2'b10;
            default:  c = '0;
        endcase
        return c;
    endfunction

    state_t     state_r;
    state_t     next_s;
    ctrl_t      ctrl_r;
    logic       op_bad_s;
    logic [2:0] funct_op_s;
    logic       funct_bad_s;

    // Next-state selection plus opcode/funct legality decode.
    always_comb begin
        next_s      = FETCH;
        op_bad_s    = 1'b0;
        funct_op_s  = 3'b000;
        funct_bad_s = 1'b0;
        case (funct)
            6'b100000: funct_op_s = 3'b000;
            6'b100010: funct_op_s = 3'b001;
            6'b100100: funct_op_s = 3'b010;
            6'b100101: funct_op_s = 3'b011;
            6'b101010: funct_op_s = 3'b100;
            default:   funct_bad_s = 1'b1;
        endcase
        case (state_r)
            FETCH:    next_s = memReady ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_s = MEMADR;
                    OP_RTYPE:     next_s = EXECUTE;
                    OP_BEQ:       next_s = BRANCH;
                    OP_ADDI:      next_s = ADDIEXEC;
                    OP_J:         next_s = JUMP;
                    default: begin
                        next_s   = FETCH;
                        op_bad_s = 1'b1;
                    end
                endcase
            end
            MEMADR:   next_s = (opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:    next_s = memReady ? MEMWB : MEMRD;
            MEMWB:    next_s = FETCH;
            MEMWR:    next_s = memReady ? FETCH : MEMWR;
            EXECUTE:  next_s = ALUWB;
            ALUWB:    next_s = FETCH;
            BRANCH:   next_s = FETCH;
            ADDIEXEC: next_s = ADDIWB;
            ADDIWB:   next_s = FETCH;
            JUMP:     next_s = FETCH;
            default:  next_s = FETCH;
        endcase
    end

    // State and registered Moore controls; reset forces FETCH and its controls in the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= FETCH;
            ctrl_r  <= moore_ctrl(FETCH);
        end else begin
            state_r <= next_s;
            ctrl_r  <= moore_ctrl(next_s);
        end
    end

    // Input-dependent controls, gated by the current state.
    always_comb begin
        pcEn      = 1'b0;
        irWrite   = 1'b0;
        illegalOp = 1'b0;
        aluOp     = ctrl_r.alu_op;
        case (state_r)
            FETCH: begin
                pcEn    = memReady;
                irWrite = memReady;
            end
            DECODE:  illegalOp = op_bad_s;
            EXECUTE: begin
                aluOp     = funct_op_s;
                illegalOp = funct_bad_s;
            end
            BRANCH:  pcEn = zeroFlag;
            JUMP:    pcEn = 1'b1;
            default: pcEn = 1'b0;
        endcase
    end

    assign aluSrcA  = ctrl_r.alu_src_a;
    assign aluSrcB  = ctrl_r.alu_src_b;
    assign pcSrc    = ctrl_r.pc_src;
    assign iorD     = ctrl_r.ior_d;
    assign memWrite = ctrl_r.mem_write;
    assign regDst   = ctrl_r.reg_dst;
    assign memToReg = ctrl_r.mem_to_reg;
    assign regWrite = ctrl_r.reg_write;
    assign state    = state_r;

endmodule

// File: tb/tb_mips_control_fsm.sv
// Scoreboard bench for mips_control_fsm: the driver queues hand-derived expected outputs per cycle,
// and a negedge monitor pops and compares them against the DUT.
module tb_mips_control_fsm;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zeroFlag;
    logic       memReady;
    logic [2:0] aluOp;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] pcSrc;
    logic       iorD, irWrite, memWrite, regDst, memToReg, regWrite, pcEn, illegalOp;
    logic [3:0] state;

    mips_control_fsm dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .zeroFlag(zeroFlag), .memReady(memReady), .aluOp(aluOp),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .pcSrc(pcSrc), .iorD(iorD),
        .irWrite(irWrite), .memWrite(memWrite), .regDst(regDst),
        .memToReg(memToReg), .regWrite(regWrite), .pcEn(pcEn),
        .illegalOp(illegalOp), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3;
    localparam logic [3:0] S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_EXEC = 4'd6, S_ALUWB = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8, S_ADDIEX = 4'd9, S_ADDIWB = 4'd10, S_JUMP = 4'd11;
    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010, BAD = 6'b111111;

    typedef struct {
        logic        chk;
        string       name;
        logic [19:0] v;
    } rec_t;

    rec_t        q[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    rec_t        mon_r;
    logic [19:0] act;

    // Table of state-only controls, written from the control table:
    // {aluSrcA, aluSrcB[1:0], pcSrc[1:0], iorD, memWrite, regDst, memToReg, regWrite}
    function automatic logic [9:0] moore(input logic [3:0] s);
        case (s)
            S_FETCH:  return 10'b0_01_00_00000;
            S_DECODE: return 10'b0_11_00_00000;
            S_MEMADR: return 10'b1_10_00_00000;
            S_MEMRD:  return 10'b0_00_00_10000;
            S_MEMWB:  return 10'b0_00_00_00011;
            S_MEMWR:  return 10'b0_00_00_11000;
            S_EXEC:   return 10'b1_00_00_00000;
            S_ALUWB:  return 10'b0_00_00_00101;
            S_BRANCH: return 10'b1_00_01_00000;
            S_ADDIEX: return 10'b1_10_00_00000;
            S_ADDIWB: return 10'b0_00_00_00001;
            S_JUMP:   return 10'b0_00_10_00000;
            default:  return 10'b0_00_00_00000;
        endcase
    endfunction

    task automatic step(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                        input logic zf, input logic mr, input logic chk,
                        input logic [3:0] es, input logic [2:0] eop, input logic epc,
                        input logic eir, input logic eill, input string nm);
        rec_t       r;
        logic [9:0] m;
        @(posedge clk);
        #1;
        reset    = rst;
        opcode   = op;
        funct    = fn;
        zeroFlag = zf;
        memReady = mr;
        m        = moore(es);
        r.chk    = chk;
        r.name   = nm;
        r.v      = {es, eop, m[9:4], eir, m[3:0], epc, eill};
        q.push_back(r);
    endtask

    task automatic cyc(input logic [5:0] op, input logic [5:0] fn, input logic zf, input logic mr,
                       input logic [3:0] es, input logic [2:0] eop, input logic epc,
                       input logic eir, input logic eill, input string nm);
        step(1'b0, op, fn, zf, mr, 1'b1, es, eop, epc, eir, eill, nm);
    endtask

    // Monitor: compare every presented cycle against the queued expectation.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            mon_r = q.pop_front();
            if (mon_r.chk) begin
                act = {state, aluOp, aluSrcA, aluSrcB, pcSrc, iorD, irWrite, memWrite,
                       regDst, memToReg, regWrite, pcEn, illegalOp};
                n_chk = n_chk + 1;
                if (act !== mon_r.v) begin
                    n_fail = n_fail + 1;
                    $display("FAIL %s: got %b required %b (state,aluOp,A,B,pcSrc,iorD,irW,memW,regDst,m2r,regW,pcEn,ill)",
                             mon_r.name, act, mon_r.v);
                end
                n_chk = n_chk + 1;
                if ((pcEn && regWrite) || (pcEn && memWrite) || (regWrite && memWrite)) begin
                    n_fail = n_fail + 1;
                    $display("FAIL strobe_excl_%s: pcEn=%b regWrite=%b memWrite=%b required at most one",
                             mon_r.name, pcEn, regWrite, memWrite);
                end
            end
        end
    end

    logic [5:0] fn_tab [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
    logic [2:0] op_tab [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b000};
    logic       ill_tab[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        logic mr_x;
        reset = 1'b1; opcode = 6'd0; funct = 6'd0; zeroFlag = 1'b0; memReady = 1'b0;
        step(1'b1, LW, 6'd0, 1'b0, 1'b0, 1'b0, S_FETCH, 3'd0, 1'b0, 1'b0, 1'b0, "pre_reset");
        step(1'b1, LW, 6'd0, 1'b0, 1'b0, 1'b1, S_FETCH, 3'd0, 1'b0, 1'b0, 1'b0, "reset_mr0");
        step(1'b1, LW, 6'd0, 1'b0, 1'b1, 1'b1, S_FETCH, 3'd0, 1'b1, 1'b1, 1'b0, "reset_mr1");

        // lw: 0,1,2,3,4 then FETCH
        cyc(LW, 6'd0, 1'b0, 1'b1, S_FETCH,  3'd0, 1'b1, 1'b1, 1'b0, "lw_fetch");
        cyc(LW, 6'd0, 1'b0, 1'b1, S_DECODE, 3'd0, 1'b0, 1'b0, 1'b0, "lw_decode");
        cyc(LW, 6'd0, 1'b0, 1'b1, S_MEMADR, 3'd0, 1'b0, 1'b0, 1'b0, "lw_memadr");
        cyc(LW, 6'd0, 1'b0, 1'b1, S_MEMRD,  3'd0, 1'b0, 1'b0, 1'b0, "lw_memrd");
        cyc(LW, 6'd0, 1'b0, 1'b1, S_MEMWB,  3'd0, 1'b0, 1'b0, 1'b0, "lw_memwb");

        // R-type over every funct, including an illegal one; memReady low in one pass must not matter
        for (int i = 0; i < 6; i++) begin
            mr_x = (i == 2) ? 1'b0 : 1'b1;
            cyc(RT, fn_tab[i], 1'b0, 1'b1, S_FETCH,  3'd0, 1'b1, 1'b1, 1'b0, "rt_fetch");
            cyc(RT, fn_tab[i], 1'b0, mr_x, S_DECODE, 3'd0, 1'b0, 1'b0, 1'b0, "rt_decode");
            cyc(RT, fn_tab[i], 1'b0, mr_x, S_EXEC,   op_tab[i], 1'b0, 1'b0, ill_tab[i], "rt_execute");
            cyc(RT, fn_tab[i], 1'b0, mr_x, S_ALUWB,  3'd0, 1'b0, 1'b0, 1'b0, "rt_aluwb");
        end

        // beq taken then not taken
        cyc(BEQ, 6'd0, 1'b1, 1'b1, S_FETCH,  3'd0, 1'b1, 1'b1, 1'b0, "beq1_fetch");
        cyc(BEQ, 6'd0, 1'b1, 1'b1, S_DECODE, 3'd0, 1'b0, 1'b0, 1'b0, "beq1_decode");
        cyc(BEQ, 6'd0, 1'b1, 1'b1, S_BRANCH, 3'd1, 1'b1, 1'b0, 1'b0, "beq1_branch");
        cyc(BEQ, 6'd0, 1'b0, 1'b1, S_FETCH,  3'd0, 1'b1, 1'b1, 1'b0, "beq0_fetch");
        cyc(BEQ, 6'd0, 1'b0, 1'b1, S_DECODE, 3'd0, 1'b0, 1'b0, 1'b0, "beq0_decode");
        cyc(BEQ, 6'd0, 1'b0, 1'b1, S_BRANCH, 3'd1, 1'b0, 1'b0, 1'b0, "beq0_branch");

        // addi, with memReady low in non-gated states
        cyc(ADDI, 6'd0, 1'b0, 1'b1, S_FETCH,  3'd0, 1'b1, 1'b1, 1'b0, "addi_fetch");
        cyc(ADDI, 6'd0, 1'b0, 1'b0, S_DECODE, 3'd0, 1'b0, 1'b0, 1'b0, "addi_decode");
        cyc(ADDI, 6'd0, 1'b0, 1'b0, S_ADDIEX, 3'd0, 1'b0, 1'b0, 1'b0, "addi_exec");
        cyc(ADDI, 6'd0, 1'b0, 1'b0, S_ADDIWB, 3'd0, 1'b0, 1'b0, 1'b0, "addi_wb");

        // j
        cyc(JMP, 6'd0, 1'b0, 1'b1, S_FETCH,  3'd0, 1'b1, 1'b1, 1'b0, "j_fetch");
        cyc(JMP, 6'd0, 1'b0, 1'b1, S_DECODE, 3'd0, 1'b0, 1'b0, 1'b0, "j_decode");
        cyc(JMP, 6'd0, 1'b0, 1'b1, S_JUMP,   3'd0, 1'b1, 1'b0, 1'b0, "j_jump");

        // illegal opcode: two cycles, flag only in DECODE
        cyc(BAD, 6'd0, 1'b0, 1'b1, S_FETCH,  3'd0, 1'b1, 1'b1, 1'b0, "ill_fetch");
        cyc(BAD, 6'd0, 1'b0, 1'b1, S_DECODE, 3'd0, 1'b0, 1'b0, 1'b1, "ill_decode");

        // sw with a FETCH stall and a three-cycle MEMWR stall
        cyc(SW, 6'd0, 1'b0, 1'b0, S_FETCH,  3'd0, 1'b0, 1'b0, 1'b0, "sw_fetch_stall");
        cyc(SW, 6'd0, 1'b0, 1'b1, S_FETCH,  3'd0, 1'b1, 1'b1, 1'b0, "sw_fetch");
        cyc(SW, 6'd0, 1'b0, 1'b1, S_DECODE, 3'd0, 1'b0, 1'b0, 1'b0, "sw_decode");
        cyc(SW, 6'd0, 1'b0, 1'b1, S_MEMADR, 3'd0, 1'b0, 1'b0, 1'b0, "sw_memadr");
        for (int i = 0; i < 3; i++)
            cyc(SW, 6'd0, 1'b0, 1'b0, S_MEMWR, 3'd0, 1'b0, 1'b0, 1'b0, "sw_memwr_stall");
        cyc(SW, 6'd0, 1'b0, 1'b1, S_MEMWR,  3'd0, 1'b0, 1'b0, 1'b0, "sw_memwr_ready");

        // reset during a MEMRD stall, then a clean lw
        cyc(LW, 6'd0, 1'b0, 1'b1, S_FETCH,  3'd0, 1'b1, 1'b1, 1'b0, "rlw_fetch");
        cyc(LW, 6'd0, 1'b0, 1'b1, S_DECODE, 3'd0, 1'b0, 1'b0, 1'b0, "rlw_decode");
        cyc(LW, 6'd0, 1'b0, 1'b0, S_MEMADR, 3'd0, 1'b0, 1'b0, 1'b0, "rlw_memadr");
        cyc(LW, 6'd0, 1'b0, 1'b0, S_MEMRD,  3'd0, 1'b0, 1'b0, 1'b0, "rlw_memrd_stall");
        step(1'b1, LW, 6'd0, 1'b0, 1'b0, 1'b1, S_MEMRD, 3'd0, 1'b0, 1'b0, 1'b0, "rlw_memrd_reset");
        cyc(LW, 6'd0, 1'b0, 1'b1, S_FETCH,  3'd0, 1'b1, 1'b1, 1'b0, "post_rst_fetch");
        cyc(LW, 6'd0, 1'b0, 1'b1, S_DECODE, 3'd0, 1'b0, 1'b0, 1'b0, "post_rst_decode");
        cyc(LW, 6'd0, 1'b0, 1'b1, S_MEMADR, 3'd0, 1'b0, 1'b0, 1'b0, "post_rst_memadr");
        cyc(LW, 6'd0, 1'b0, 1'b1, S_MEMRD,  3'd0, 1'b0, 1'b0, 1'b0, "post_rst_memrd");
        cyc(LW, 6'd0, 1'b0, 1'b1, S_MEMWB,  3'd0, 1'b0, 1'b0, 1'b0, "post_rst_memwb");
        cyc(LW, 6'd0, 1'b0, 1'b1, S_FETCH,  3'd0, 1'b1, 1'b1, 1'b0, "post_rst_done");

        repeat (2) @(posedge clk);
        n_chk = n_chk + 1;
        if (q.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
